// File: rtl/shift_reg_bank.sv
// shift_reg_bank: CHANNELS independent shift lanes of LENGTH words each.
// Supports parallel load, serial write, clear, rotate and a self-timed read
// burst whose channels can be diagonally staggered (channel c starts c
// cycles late) to feed the edge of a systolic array.
//
// Output qualifier: read_valid[c] high means data_read lane c holds a word
// popped on the previous edge. There is no ready; the consumer must accept
// every word in the cycle it is presented.
module shift_reg_bank #(
  parameter int DATA_WIDTH = 8,
  parameter int LENGTH     = 4,
  parameter int CHANNELS   = 4,
  localparam int LW        = $clog2(LENGTH + 1)
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [2:0]                            ctrl_code,
  input  logic                                  skew_en,
  input  logic [CHANNELS*LENGTH*DATA_WIDTH-1:0] data_in,
  input  logic [CHANNELS*DATA_WIDTH-1:0]        data_write,
  output logic [CHANNELS*LENGTH*DATA_WIDTH-1:0] data_out,
  output logic [CHANNELS*DATA_WIDTH-1:0]        data_read,
  output logic [CHANNELS-1:0]                   read_valid,
  output logic [LW-1:0]                         level,
  output logic                                  overflow,
  output logic                                  busy,
  output logic                                  done
);

  // Step counter must reach LENGTH+CHANNELS-2 and hold off_c+LENGTH.
  localparam int KW = (LENGTH + CHANNELS > 2) ? $clog2(LENGTH + CHANNELS) : 1;

  localparam logic [2:0] OP_HOLD   = 3'b000;
  localparam logic [2:0] OP_LOAD   = 3'b001;
  localparam logic [2:0] OP_WRITE  = 3'b010;
  localparam logic [2:0] OP_READ   = 3'b011;
  localparam logic [2:0] OP_CLEAR  = 3'b100;
  localparam logic [2:0] OP_ROTATE = 3'b101;

  localparam logic [KW-1:0] LEN_K  = KW'(LENGTH);
  localparam logic [KW-1:0] LAST_N = KW'(LENGTH - 1);
  localparam logic [KW-1:0] LAST_S = KW'(LENGTH + CHANNELS - 2);
  localparam logic [LW-1:0] FULL   = LW'(LENGTH);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] mem [CHANNELS][LENGTH];
  logic [DATA_WIDTH-1:0] rd_q [CHANNELS];
  logic [KW-1:0]         k_q;
  logic                  skew_q;

  logic                  start;
  logic                  stepping;
  logic [KW-1:0]         cur_k;
  logic                  cur_skew;
  logic                  burst_last;
  logic [CHANNELS-1:0]   act;

  // Burst step decode: the start edge runs step 0 with the live skew_en,
  // later steps use the skew latched at start.
  always_comb begin
    logic [KW-1:0] off;
    off        = '0;
    start      = (state_q == IDLE) && (ctrl_code == OP_READ);
    stepping   = start || (state_q == RUN);
    cur_k      = start ? '0 : k_q;
    cur_skew   = start ? skew_en : skew_q;
    burst_last = (cur_k == (cur_skew ? LAST_S : LAST_N));
    act        = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      off    = cur_skew ? KW'(c) : '0;
      act[c] = stepping && (cur_k >= off) && (cur_k < off + LEN_K);
    end
  end

  // Next-state: a burst stays in RUN until the edge executing its last step.
  always_comb begin
    state_d = state_q;
    if (stepping) begin
      state_d = burst_last ? IDLE : RUN;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath: storage, burst outputs, level, overflow and done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < CHANNELS; c++) begin
        for (int i = 0; i < LENGTH; i++) mem[c][i] <= '0;
        rd_q[c] <= '0;
      end
      read_valid <= '0;
      level      <= '0;
      overflow   <= 1'b0;
      done       <= 1'b0;
      k_q        <= '0;
      skew_q     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (stepping) begin
        for (int c = 0; c < CHANNELS; c++) begin
          if (act[c]) begin
            rd_q[c]       <= mem[c][0];
            read_valid[c] <= 1'b1;
            for (int i = 0; i < LENGTH - 1; i++) mem[c][i] <= mem[c][i+1];
            mem[c][LENGTH-1] <= '0;
          end else begin
            rd_q[c]       <= '0;
            read_valid[c] <= 1'b0;
          end
        end
        if (burst_last) begin
          done  <= 1'b1;
          level <= '0;
          k_q   <= '0;
        end else begin
          k_q <= cur_k + KW'(1);
        end
        skew_q <= cur_skew;
      end else begin
        for (int c = 0; c < CHANNELS; c++) rd_q[c] <= '0;
        read_valid <= '0;
        case (ctrl_code)
          OP_LOAD: begin
            for (int c = 0; c < CHANNELS; c++)
              for (int i = 0; i < LENGTH; i++)
                mem[c][i] <= data_in[(c*LENGTH+i)*DATA_WIDTH +: DATA_WIDTH];
            level <= FULL;
          end
          OP_WRITE: begin
            for (int c = 0; c < CHANNELS; c++) begin
              for (int i = 0; i < LENGTH - 1; i++) mem[c][i] <= mem[c][i+1];
              mem[c][LENGTH-1] <= data_write[c*DATA_WIDTH +: DATA_WIDTH];
            end
            if (level == FULL) overflow <= 1'b1;
            else               level    <= level + LW'(1);
          end
          OP_CLEAR: begin
            for (int c = 0; c < CHANNELS; c++)
              for (int i = 0; i < LENGTH; i++) mem[c][i] <= '0;
            level    <= '0;
            overflow <= 1'b0;
          end
          OP_ROTATE: begin
            for (int c = 0; c < CHANNELS; c++) begin
              for (int i = 0; i < LENGTH - 1; i++) mem[c][i] <= mem[c][i+1];
              mem[c][LENGTH-1] <= mem[c][0];
            end
          end
          default: ; // HOLD and unused codes
        endcase
      end
    end
  end

  assign busy = (state_q == RUN);

  // Flatten storage and burst words onto the packed ports.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    assign data_read[c*DATA_WIDTH +: DATA_WIDTH] = rd_q[c];
    for (genvar i = 0; i < LENGTH; i++) begin : g_el
      assign data_out[(c*LENGTH+i)*DATA_WIDTH +: DATA_WIDTH] = mem[c][i];
    end
  end

endmodule

// File: tb/tb_shift_reg_bank.sv
// tb_shift_reg_bank: directed and random checks of shift_reg_bank
// (DATA_WIDTH=8, LENGTH=4, CHANNELS=4) against a small reference model.
module tb_shift_reg_bank;

  localparam int DW  = 8;
  localparam int LEN = 4;
  localparam int CH  = 4;
  localparam int LW  = $clog2(LEN + 1);

  localparam logic [2:0] OP_HOLD   = 3'b000;
  localparam logic [2:0] OP_LOAD   = 3'b001;
  localparam logic [2:0] OP_WRITE  = 3'b010;
  localparam logic [2:0] OP_READ   = 3'b011;
  localparam logic [2:0] OP_CLEAR  = 3'b100;
  localparam logic [2:0] OP_ROTATE = 3'b101;

  logic                   clk;
  logic                   reset;
  logic [2:0]             ctrl_code;
  logic                   skew_en;
  logic [CH*LEN*DW-1:0]   data_in;
  logic [CH*DW-1:0]       data_write;
  logic [CH*LEN*DW-1:0]   data_out;
  logic [CH*DW-1:0]       data_read;
  logic [CH-1:0]          read_valid;
  logic [LW-1:0]          level;
  logic                   overflow;
  logic                   busy;
  logic                   done;

  shift_reg_bank #(.DATA_WIDTH(DW), .LENGTH(LEN), .CHANNELS(CH)) dut (
    .clk        (clk),
    .reset      (reset),
    .ctrl_code  (ctrl_code),
    .skew_en    (skew_en),
    .data_in    (data_in),
    .data_write (data_write),
    .data_out   (data_out),
    .data_read  (data_read),
    .read_valid (read_valid),
    .level      (level),
    .overflow   (overflow),
    .busy       (busy),
    .done       (done)
  );

  // Clock and counters.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Scoreboard entry: {done, busy, read_valid, data_read}.
  logic [CH*DW+CH+1:0] exp_q[$];

  // Reference model of the storage.
  int m [CH][LEN];
  int m_level;
  int m_ovf;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] model_out();
    logic [127:0] v;
    v = '0;
    for (int c = 0; c < CH; c++)
      for (int i = 0; i < LEN; i++)
        v[(c*LEN+i)*DW +: DW] = m[c][i][DW-1:0];
    return v;
  endfunction

  task automatic model_zero();
    for (int c = 0; c < CH; c++)
      for (int i = 0; i < LEN; i++) m[c][i] = 0;
  endtask

  task automatic check_state(input string tag);
    check({tag, ".data_out"}, data_out, model_out());
    check({tag, ".level"}, level, m_level);
    check({tag, ".overflow"}, overflow, m_ovf);
  endtask

  // Driver tasks.
  task automatic do_load(input bit rnd);
    int v;
    for (int c = 0; c < CH; c++)
      for (int i = 0; i < LEN; i++) begin
        v = rnd ? int'($urandom_range(0, 255)) : 16*c + i + 1;
        m[c][i] = v;
        data_in[(c*LEN+i)*DW +: DW] = v[DW-1:0];
      end
    m_level   = LEN;
    ctrl_code = OP_LOAD;
    tick();
    ctrl_code = OP_HOLD;
  endtask

  task automatic do_write(input int base);
    int v;
    if (m_level == LEN) m_ovf = 1;
    else                m_level++;
    for (int c = 0; c < CH; c++) begin
      v = base + 16*c;
      data_write[c*DW +: DW] = v[DW-1:0];
      for (int i = 0; i < LEN - 1; i++) m[c][i] = m[c][i+1];
      m[c][LEN-1] = v;
    end
    ctrl_code = OP_WRITE;
    tick();
    ctrl_code = OP_HOLD;
  endtask

  task automatic do_clear();
    model_zero();
    m_level   = 0;
    m_ovf     = 0;
    ctrl_code = OP_CLEAR;
    tick();
    ctrl_code = OP_HOLD;
  endtask

  task automatic do_rotate();
    int t;
    for (int c = 0; c < CH; c++) begin
      t = m[c][0];
      for (int i = 0; i < LEN - 1; i++) m[c][i] = m[c][i+1];
      m[c][LEN-1] = t;
    end
    ctrl_code = OP_ROTATE;
    tick();
    ctrl_code = OP_HOLD;
  endtask

  // Burst: expectations come from a snapshot of the model taken at start.
  task automatic read_burst(input logic sk, input bit toggle);
    int                  bl;
    int                  off;
    logic [CH-1:0]       v;
    logic [CH*DW-1:0]    d;
    logic [CH*DW+CH+1:0] e;
    bl = LEN + (sk ? CH - 1 : 0);
    for (int k = 0; k < bl; k++) begin
      v = '0;
      d = '0;
      for (int c = 0; c < CH; c++) begin
        off = sk ? c : 0;
        if (k >= off && k < off + LEN) begin
          v[c] = 1'b1;
          d[c*DW +: DW] = m[c][k-off][DW-1:0];
        end
      end
      exp_q.push_back({(k == bl - 1), (k != bl - 1), v, d});
    end
    model_zero();
    m_level   = 0;
    ctrl_code = OP_READ;
    skew_en   = sk;
    tick();
    ctrl_code = OP_HOLD;
    skew_en   = ~sk;
    for (int k = 0; k < bl; k++) begin
      if (exp_q.size() == 0) begin
        check("burst.queue_empty", 1, 0);
        break;
      end
      e = exp_q.pop_front();
      check($sformatf("burst.step%0d", k), {done, busy, read_valid, data_read}, e);
      if (k < bl - 1) begin
        if (toggle) begin
          ctrl_code = k[0] ? OP_CLEAR : OP_LOAD;
          data_in   = {$urandom, $urandom, $urandom, $urandom};
        end
        tick();
      end
    end
    ctrl_code = OP_HOLD;
    tick();
    check("burst.after", {done, busy, read_valid, data_read}, '0);
    check_state("burst.after");
  endtask

  // Stimulus.
  initial begin
    reset      = 1'b1;
    ctrl_code  = OP_HOLD;
    skew_en    = 1'b0;
    data_in    = '0;
    data_write = '0;
    model_zero();
    m_level = 0;
    m_ovf   = 0;

    // Reset and idle state.
    repeat (4) @(posedge clk);
    #1;
    check("reset.held", {data_out, data_read, read_valid, level, overflow, busy, done}, '0);
    reset = 1'b0;
    tick();
    check("reset.rel.outs", {data_read, read_valid, busy, done}, '0);
    check_state("reset.rel");

    // LOAD then unskewed burst.
    do_load(0);
    check_state("load");
    read_burst(1'b0, 1'b0);

    // LOAD then skewed burst with ctrl_code toggled mid-burst.
    do_load(0);
    read_burst(1'b1, 1'b1);

    // Burst with level==0 still emits valid zero words.
    read_burst(1'b1, 1'b0);

    // Serial write, saturation and overflow.
    do_clear();
    do_write(5); do_write(6); do_write(7);
    check_state("write3");
    do_write(8);
    check_state("write4");
    do_write(9);
    check_state("write5.ovf");
    do_clear();
    check_state("clear");

    // Rotate.
    do_load(0);
    do_rotate();
    check_state("rotate1");
    do_rotate(); do_rotate(); do_rotate();
    check_state("rotate4");

    // Random load and burst.
    for (int r = 0; r < 4; r++) begin
      do_load(1);
      read_burst(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Async reset in the middle of a skewed burst.
    do_load(0);
    ctrl_code = OP_READ;
    skew_en   = 1'b1;
    tick();
    ctrl_code = OP_HOLD;
    repeat (3) tick();
    check("midrst.pre.busy", busy, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("midrst.async", {data_out, data_read, read_valid, level, overflow, busy, done}, '0);
    tick();
    check("midrst.held.done", done, 1'b0);
    reset = 1'b0;
    model_zero();
    m_level = 0;
    m_ovf   = 0;
    tick();
    check("midrst.rel", {busy, done, read_valid}, '0);
    check_state("midrst.rel");
    do_load(0);
    read_burst(1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/shift_reg_bank.md
Name: shift_reg_bank

Overview:
- Multi-channel successor to the single-lane shift register. Holds CHANNELS independent lanes of LENGTH words each.
- Supports parallel load, serial write, clear and rotate.
- Supports a self-timed read burst with optional diagonal skew: channel c starts c cycles late, which is the staggered feed pattern for systolic array row/column inputs.
- Sits between the input buffers and the array edge.

Parameters:
- DATA_WIDTH, 8, bits per word
- LENGTH, 4, words per channel (>=1)
- CHANNELS, 4, number of parallel lanes (>=1)
- LW, $clog2(LENGTH+1), width of level output (derived, not overridden)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high reset
- ctrl_code  in  3  operation select, sampled in IDLE only
- skew_en  in  1  skew select, sampled on the READ start edge
- data_in  in  CHANNELS*LENGTH*DATA_WIDTH  parallel load; ch c elem i at [(c*LENGTH+i)*DATA_WIDTH +: DATA_WIDTH]
- data_write  in  CHANNELS*DATA_WIDTH  serial write word per channel; ch c at [c*DATA_WIDTH +: DATA_WIDTH]
- data_out  out  CHANNELS*LENGTH*DATA_WIDTH  current register contents, same packing as data_in
- data_read  out  CHANNELS*DATA_WIDTH  registered burst output per channel
- read_valid  out  CHANNELS  per-channel qualifier for data_read
- level  out  LW  count of valid words (common to all lanes)
- overflow  out  1  sticky: a WRITE occurred while level==LENGTH
- busy  out  1  high while a read burst is in progress
- done  out  1  one-cycle pulse when a burst completes

Behaviour:
- Reset (async, any time, including mid-burst):
  - All storage, data_read, read_valid, level, overflow, busy and done go to 0; FSM goes to IDLE.
  - An aborted burst never pulses done.
- FSM states: IDLE, RUN. busy = (state==RUN).
- ctrl_code in IDLE, acting at each rising edge:
  - 000 HOLD: no change.
  - 001 LOAD: all elements <= data_in; level <= LENGTH.
  - 010 WRITE: per channel, elem i <= elem i+1 and elem LENGTH-1 <= data_write word.
    - level increments, saturating at LENGTH.
    - If level was already LENGTH, overflow <= 1 and the oldest word is lost.
  - 011 READ: starts a burst (see below).
  - 100 CLEAR: all elements, level and overflow <= 0.
  - 101 ROTATE: elem i <= elem i+1; elem LENGTH-1 <= old elem 0; level unchanged.
  - 110, 111: treated as HOLD.
- Read burst:
  - BURST_LEN = LENGTH + (skew_en ? CHANNELS-1 : 0), using skew_en sampled at the start edge.
  - A step counter k runs 0..BURST_LEN-1. The start edge itself executes step 0.
  - Channel offset off_c = skew ? c : 0. Channel c is active at step k when off_c <= k < off_c+LENGTH.
  - Active channel at step edge:
    - data_read_c <= elem 0; read_valid_c <= 1.
    - Shift toward index 0, zero-filling elem LENGTH-1.
  - Inactive channel: read_valid_c <= 0, data_read_c <= 0, contents held.
  - Output is registered: the word is visible in the cycle after its step edge.
  - If BURST_LEN>1, state goes to RUN after the start edge. The edge executing step BURST_LEN-1 returns to IDLE, sets done <= 1 for exactly one cycle, and sets level <= 0.
  - If BURST_LEN==1, the FSM stays IDLE and done pulses after the start edge.
  - ctrl_code and skew_en are ignored while RUN; no queuing.
  - A new READ may start on the edge immediately following the done-setting edge.
- read_valid and data_read return to 0 on the first edge where a channel is not active.
- A READ with level==0 still runs the full burst and outputs zeros with read_valid=1. Validity of content is the level's responsibility, not the bank's.

Test Plan (DATA_WIDTH=8, LENGTH=4, CHANNELS=4):
1. Reset held 4 cycles, then released with ctrl_code=000 -> data_out, data_read, read_valid, level, overflow, busy and done all 0. Reasserting reset at any later point zeroes them asynchronously, before the next edge.
2. LOAD with ch c elem i = 16c+i+1, then READ with skew_en=0:
   - Expected: 4 output cycles; ch0 reads 1,2,3,4, ch3 reads 49,50,51,52, all read_valid=4'hF together.
   - busy high 3 cycles; done pulses once with the last word.
   - Afterwards level=0 and data_out all zero.
3. Same LOAD, READ with skew_en=1:
   - Expected: 7 steps; read_valid sequence 0001, 0011, 0111, 1111, 1110, 1100, 1000.
   - ch2 first word 33 appears in the third output cycle.
   - done after step 6; ctrl_code toggled to LOAD/CLEAR mid-burst has no effect.
4. CLEAR, then WRITE 5,6,7 -> ch elems (0..3) = 0,5,6,7, level=3, overflow=0. Then WRITE 8,9 -> elems 6,7,8,9, level=4, overflow=1. CLEAR -> overflow=0.
5. LOAD 1,2,3,4 on ch0, then ROTATE once -> 2,3,4,1; ROTATE 3 more -> 1,2,3,4; level stays 4.
6. Reset asserted mid-edge-cycle at step 3 of a skewed burst -> immediate all-zero outputs, busy=0, no done pulse. A subsequent LOAD+READ behaves as in scenario 2.
